// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, threshold flags, sticky error flags
// and a choice of registered-read or first-word-fall-through read port.
module sync_fifo #(
  parameter int DATASIZE      = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                wren,
  input  logic                rden,
  input  logic                clr_err,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [AW:0]         count,
  output logic                overflow,
  output logic                underflow
);

  localparam int          CW       = AW + 1;
  localparam logic [AW:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [AW:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [AW:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  logic [DATASIZE-1:0] mem_r [DEPTH];
  logic [AW:0]         wptr_r;
  logic [AW:0]         rptr_r;
  logic [AW:0]         count_s;
  logic                full_s;
  logic                empty_s;
  logic                wr_acc_s;
  logic                rd_acc_s;
  logic                overflow_r;
  logic                underflow_r;

  // Status is decoded purely from the registered pointers, so the extra
  // pointer bit distinguishes full from empty without a separate counter.
  assign count_s  = wptr_r - rptr_r;
  assign full_s   = (count_s == DEPTH_C);
  assign empty_s  = (count_s == {CW{1'b0}});
  assign wr_acc_s = wren && !full_s;
  assign rd_acc_s = rden && !empty_s;

  assign count        = count_s;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_s >= AFULL_C);
  assign almost_empty = (count_s <= AEMPTY_C);
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

  // Pointer advance on accepted operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r <= {CW{1'b0}};
      rptr_r <= {CW{1'b0}};
    end else begin
      if (wr_acc_s) wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
      if (rd_acc_s) rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents survive reset but nothing is written during it.
  always_ff @(posedge clk) begin
    if (wr_acc_s && !rst) mem_r[wptr_r[AW-1:0]] <= wdata;
  end

  // Sticky error flags; a new error in the same cycle beats clr_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wren && full_s)     overflow_r <= 1'b1;
      else if (clr_err)       overflow_r <= 1'b0;
      if (rden && empty_s)    underflow_r <= 1'b1;
      else if (clr_err)       underflow_r <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATASIZE-1:0] rdata_r;
      logic                rvalid_r;

      // Registered read port: rdata only changes on an accepted read.
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_r  <= {DATASIZE{1'b0}};
          rvalid_r <= 1'b0;
        end else begin
          rvalid_r <= rd_acc_s;
          if (rd_acc_s) rdata_r <= mem_r[rptr_r[AW-1:0]];
        end
      end

      assign rdata  = rdata_r;
      assign rvalid = rvalid_r;
    end else begin : g_fwft_read
      assign rdata  = mem_r[rptr_r[AW-1:0]];
      assign rvalid = !empty_s;
    end
  endgenerate

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATASIZE, default 8: data word width in bits, >= 1.
REQ-002 Parameter DEPTH, default 16: number of storage words, power of two, >= 2; AW = $clog2(DEPTH).
REQ-003 Parameter AFULL_THRESH, default DEPTH-2: occupancy at or above which almost_full asserts.
REQ-004 Parameter AEMPTY_THRESH, default 2: occupancy at or below which almost_empty asserts.
REQ-005 Parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 wdata  input  DATASIZE  write data.
REQ-009 wren  input  1  write request.
REQ-010 rden  input  1  read request (FWFT=1: acknowledge of presented head word).
REQ-011 clr_err  input  1  clears the sticky error flags.
REQ-012 rdata  output  DATASIZE  read data.
REQ-013 rvalid  output  1  rdata holds a newly read word (FWFT=0) / head word is valid (FWFT=1).
REQ-014 full, empty  output  1 each  occupancy == DEPTH / occupancy == 0.
REQ-015 almost_full, almost_empty  output  1 each  threshold flags.
REQ-016 count  output  AW+1  current occupancy, 0..DEPTH.
REQ-017 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-018 Write and read pointers SHALL be AW+1 bits; low AW bits address memory; MSB is the wrap bit.
REQ-019 Write accept wr_acc = wren && !full; on wr_acc, mem[wptr[AW-1:0]] <= wdata and wptr increments.
REQ-020 Read accept rd_acc = rden && !empty; on rd_acc, rptr increments.
REQ-021 full and empty SHALL use pre-edge state: simultaneous wren and rden when full -> read accepted, write rejected; when empty -> write accepted, read rejected.
REQ-022 Simultaneous accepted read and write SHALL leave count unchanged.
REQ-023 Pointers SHALL wrap modulo 2*DEPTH; addresses wrap modulo DEPTH with no gap or skipped entry.
REQ-024 count = wptr - rptr (AW+1-bit modular); full = (count == DEPTH); empty = (count == 0).
REQ-025 almost_full = (count >= AFULL_THRESH); almost_empty = (count <= AEMPTY_THRESH).
REQ-026 All status outputs SHALL be decoded from registered state only; they reflect an accepted operation in the cycle after its edge.
REQ-027 FWFT=0: on rd_acc, rdata <= mem[rptr] at that edge and rvalid = 1 the following cycle; otherwise rvalid = 0 and rdata holds its last value.
REQ-028 FWFT=1: rdata = mem[rptr[AW-1:0]] continuously, rvalid = !empty; rden acknowledges and advances to the next word.
REQ-029 A write into an empty FIFO SHALL be readable no earlier than the cycle after the write edge (no write-to-read bypass).
REQ-030 overflow sets on wren && full; underflow sets on rden && empty; both remain set until clr_err or rst.
REQ-031 When set and clr_err coincide, set SHALL win.
REQ-032 Rejected operations SHALL NOT change memory, pointers, or rdata.

Reset
REQ-033 On rst at a clk edge: wptr = rptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0 (for AFULL_THRESH > 0), rvalid = 0, rdata = 0 (FWFT=0), overflow = underflow = 0.
REQ-034 rst SHALL override wren, rden, and clr_err in the same cycle; memory contents are not cleared.
REQ-035 Reset mid-operation SHALL discard all stored words; the first read after reset returns the first word written after reset.

Verification
REQ-036 Defaults, FWFT=0: write 0x01..0x10 on 16 consecutive cycles -> full = 1 after the 16th edge, count = 16, almost_full set from count = 14; 17th write sets overflow, count stays 16.
REQ-037 Full FIFO, wren = rden = 1 for one cycle -> read returns 0x01, write rejected, count = 15, overflow = 1.
REQ-038 Read 16 words -> rdata sequence 0x01..0x10, rvalid pulses one cycle after each read, empty = 1; an extra rden sets underflow, and rdata holds 0x10.
REQ-039 Wrap: 40 alternating single write/read pairs of incrementing data -> every read matches its write, count toggles 0/1, no error flags.
REQ-040 FWFT=1: write 0xA5 into an empty FIFO -> next cycle rvalid = 1 and rdata = 0xA5 with no rden; rden -> empty = 1 next cycle.
REQ-041 Write 5 words, assert rst with wren = 1 -> count = 0, empty = 1, flags cleared; next write 0x3C, then read -> 0x3C.
